sd_spi_xfer_ctrl: RTL and testbench
===================================

# sd_spi_xfer_ctrl

Byte-burst sequencer for the SD-card SPI master core. It takes a transfer command (byte count, transmit source, chip-select policy) from the SD access logic and drives the core's register port. For each byte it writes the TX byte, polls status until the RX byte is ready, reads it back and streams it out. It sits between the SD command/data engine and the SPI master core's control port, and is the only master of that port.

## Interface
Parameters:
- `LEN_W`, 10: width of `cmd_len`; a command moves `cmd_len+1` bytes (1..1024).
- `FILL_BYTE`, 8'hFF: TX byte used when `cmd_fill`=1.
- `TIMEOUT_CYCLES`, 16'd20000: poll limit per byte (only with the timeout macro).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; accepted when both are high.
- `cmd_len` in LEN_W: byte count minus 1.
- `cmd_fill` in 1: 1 = send `FILL_BYTE`; 0 = take bytes from `tx_*`.
- `cmd_keep_cs` in 1: 1 = leave SS asserted after the last byte.
- `tx_valid` in 1 / `tx_ready` out 1 / `tx_data` in 8: TX byte stream.
- `rx_valid` out 1 / `rx_ready` in 1 / `rx_data` out 8: RX byte stream.
- `done` out 1: one-cycle pulse at command end.
- `err_overrun` out 1: core reported ROE or TOE during the command; valid with `done`.
- `err_timeout` out 1: poll limit expired; valid with `done`.
- `spi_select` out 1, `spi_mem_addr` out 3, `spi_read_n` out 1, `spi_write_n` out 1, `spi_wdata` out 16, `spi_rdata` in 16: SPI core register port.

## Operation
- Core registers used: addr0 RX data, addr1 TX data, addr2 status (write clears), addr3 control (bit10 = SSO). Status bits used: ROE=3, TOE=4, TMT=5, TRDY=6, RRDY=7.
- The slave-select register is left at its reset value of 1 and is never written.
- Bus access takes 3 cycles:
  - A and B: `spi_select`=1 with the access strobe low, address and data held stable.
  - C: gap cycle with all strobes inactive.
  - Read data is sampled from `spi_rdata` on the clock edge ending B.
- States:
  - IDLE: `cmd_ready`=1. On accept, latch len, fill and keep_cs; clear the error flags → CLR.
  - CLR: write addr2 (clears stale RRDY, ROE, TOE). Then → SEND if `cs_on` is already set, otherwise → CSON.
  - CSON: write addr3 = 16'h0400; set internal `cs_on` → SEND.
  - SEND:
    - If fill: write addr1 = FILL_BYTE.
    - Otherwise wait for `tx_valid`, present `tx_ready` for exactly that cycle, then write addr1 = {8'h00, tx_data}.
    - → POLL.
  - POLL: read addr2 repeatedly. OR status bits 3 and 4 into `err_overrun`. Bit 7 set → RD; otherwise repeat.
  - RD: read addr0; load `rx_data` = rdata[7:0] → OUT.
  - OUT: `rx_valid`=1 until `rx_ready`. Then:
    - count ≠ len: count++ → SEND.
    - count = len and keep_cs: → FIN.
    - count = len and not keep_cs: → CSOFF.
  - CSOFF: write addr3 = 0; clear `cs_on` → FIN.
  - FIN: pulse `done` → IDLE.
- `cs_on` persists across commands, so a keep_cs chain skips CSON.
- `rx_valid` and `tx_ready` are never high together. Commands are never accepted while busy.

## Timing
- Reset values:
  - `cmd_ready`=1; `tx_ready`, `rx_valid`, `done`, `err_*` = 0.
  - `spi_select`=0, `spi_read_n`=1, `spi_write_n`=1, `spi_mem_addr`=0, `spi_wdata`=0.
  - Internal: `cs_on`=0, state IDLE.
- Reset mid-burst returns to IDLE immediately and does not clean up SS. The SPI core must be reset together with this block (they share the system reset).
- Overhead is fixed, excluding SPI shift time and OUT stall:
  - Minimum per byte: SEND 3 + POLL 3·k + RD 3 + OUT ≥1.
  - First byte with CS: +6 (CLR, CSON).
  - Command end: CSOFF 3 + FIN 1.
- Command to first `spi_select`: 1 cycle after accept.
- `done` is asserted in FIN, one cycle after the last write or after the `rx_ready` handshake.
- Count wraps only at `cmd_len`; len=0 transfers exactly 1 byte.

## Configuration
- `SD_SPI_CTRL_TIMEOUT_EN` defined:
  - A 16-bit counter clears at SEND and increments every POLL cycle.
  - Reaching TIMEOUT_CYCLES sets `err_timeout`, abandons the remaining bytes and goes to CSOFF (always, ignoring keep_cs), then FIN.
- Undefined: no counter; POLL waits forever; `err_timeout` is tied to 0.

## Test plan
- Single byte, tx_data=8'h40, keep_cs=0, SPI model MISO returns 8'hA5:
  - Bus sequence is CLR, CSON(0x0400), TX 0x40, polls, RX, CSOFF(0x0000).
  - `rx_data`=8'hA5; `done` pulse with both errors 0; SS_n high at end.
- Fill read, len=511, fill=1:
  - 512 writes of 16'h00FF and 512 RX bytes in order.
  - Exactly one CSON and one CSOFF.
- Backpressure: `rx_ready` held low 100 cycles on byte 3:
  - `rx_valid` and `rx_data` stay stable.
  - No new addr1 write until the handshake.
- Chain: a keep_cs=1 command (2 bytes) followed by a keep_cs=0 command (1 byte):
  - The second command issues no CSON; SS_n stays low throughout; one CSOFF at the end.
- Core stalled (RRDY never set), macro defined, TIMEOUT_CYCLES=100:
  - `err_timeout`=1 with `done`; CSOFF issued.
  - With the macro undefined, the controller stays in POLL.
- Assert `reset` during POLL of byte 5:
  - Next cycle all outputs are at reset values and `cmd_ready`=1.
  - A new command then runs normally from CLR.

Source files
------------

// File: rtl/sd_spi_xfer_ctrl.sv
// Byte-burst sequencer driving the SPI master core register port for SD-card transfers.
// Optional per-byte poll timeout enabled by defining SD_SPI_CTRL_TIMEOUT_EN.
module sd_spi_xfer_ctrl #(
  parameter int          LEN_W          = 10,
  parameter logic [7:0]  FILL_BYTE      = 8'hFF,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_fill,
  input  logic             cmd_keep_cs,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             done,
  output logic             err_overrun,
  output logic             err_timeout,
  output logic             spi_select,
  output logic [2:0]       spi_mem_addr,
  output logic             spi_read_n,
  output logic             spi_write_n,
  output logic [15:0]      spi_wdata,
  input  logic [15:0]      spi_rdata
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CLR   = 4'd1;
  localparam logic [3:0] S_CSON  = 4'd2;
  localparam logic [3:0] S_SEND  = 4'd3;
  localparam logic [3:0] S_POLL  = 4'd4;
  localparam logic [3:0] S_RD    = 4'd5;
  localparam logic [3:0] S_OUT   = 4'd6;
  localparam logic [3:0] S_CSOFF = 4'd7;
  localparam logic [3:0] S_FIN   = 4'd8;

  logic [3:0]       state;
  logic [1:0]       phase;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic             fill_q;
  logic             keep_q;
  logic             cs_on;
  logic             rrdy_seen;
  logic [7:0]       tx_byte;
  logic             bus_state;
  logic             step;
  logic             last;
  logic             unused_rdata;

  assign unused_rdata = ^spi_rdata[15:8];

  assign cmd_ready = (state == S_IDLE);
  assign rx_valid  = (state == S_OUT);
  assign done      = (state == S_FIN);

`ifdef SD_SPI_CTRL_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt >= TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk) begin
    if (reset || state == S_SEND) begin
      tmo_cnt <= '0;
    end else if (state == S_POLL && tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (state == S_IDLE && cmd_valid) begin
      err_timeout <= 1'b0;
    end else if (state == S_POLL && last && !rrdy_seen && tmo_hit) begin
      err_timeout <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign err_timeout = 1'b0;
`endif

  // Phases 0/1 hold the strobe, phase 2 is the bus gap; SEND phase 0 stalls until a TX byte exists.
  always_comb begin
    bus_state = 1'b0;
    case (state)
      S_CLR, S_CSON, S_SEND, S_POLL, S_RD, S_CSOFF: bus_state = 1'b1;
      default: bus_state = 1'b0;
    endcase
    step = bus_state && !(state == S_SEND && phase == 2'd0 && !fill_q && !tx_valid);
    last = bus_state && (phase == 2'd2);
  end

  always_comb begin
    spi_select   = 1'b0;
    spi_read_n   = 1'b1;
    spi_write_n  = 1'b1;
    spi_mem_addr = '0;
    spi_wdata    = '0;
    tx_ready     = (state == S_SEND) && (phase == 2'd0) && !fill_q && tx_valid;
    if (step && phase != 2'd2) begin
      spi_select = 1'b1;
      case (state)
        S_CLR: begin
          spi_write_n  = 1'b0;
          spi_mem_addr = 3'd2;
        end
        S_CSON: begin
          spi_write_n  = 1'b0;
          spi_mem_addr = 3'd3;
          spi_wdata    = 16'h0400;
        end
        S_SEND: begin
          spi_write_n  = 1'b0;
          spi_mem_addr = 3'd1;
          if (fill_q) begin
            spi_wdata = {8'h00, FILL_BYTE};
          end else if (phase == 2'd0) begin
            spi_wdata = {8'h00, tx_data};
          end else begin
            spi_wdata = {8'h00, tx_byte};
          end
        end
        S_POLL: begin
          spi_read_n   = 1'b0;
          spi_mem_addr = 3'd2;
        end
        S_RD: begin
          spi_read_n   = 1'b0;
          spi_mem_addr = 3'd0;
        end
        S_CSOFF: begin
          spi_write_n  = 1'b0;
          spi_mem_addr = 3'd3;
        end
        default: spi_select = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      len_q       <= '0;
      count       <= '0;
      fill_q      <= 1'b0;
      keep_q      <= 1'b0;
      cs_on       <= 1'b0;
      rrdy_seen   <= 1'b0;
      tx_byte     <= '0;
      rx_data     <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (step) begin
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            len_q       <= cmd_len;
            fill_q      <= cmd_fill;
            keep_q      <= cmd_keep_cs;
            count       <= '0;
            phase       <= '0;
            err_overrun <= 1'b0;
            state       <= S_CLR;
          end
        end
        S_CLR: if (last) state <= cs_on ? S_SEND : S_CSON;
        S_CSON: begin
          if (last) begin
            cs_on <= 1'b1;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (phase == 2'd0 && step) tx_byte <= tx_data;
          if (last) state <= S_POLL;
        end
        S_POLL: begin
          if (phase == 2'd1) begin
            rrdy_seen <= spi_rdata[7];
            if (spi_rdata[3] || spi_rdata[4]) err_overrun <= 1'b1;
          end
          if (last) begin
            if (rrdy_seen) begin
              state <= S_RD;
            end
`ifdef SD_SPI_CTRL_TIMEOUT_EN
            else if (tmo_hit) begin
              state <= S_CSOFF;
            end
`endif
          end
        end
        S_RD: begin
          if (phase == 2'd1) rx_data <= spi_rdata[7:0];
          if (last) state <= S_OUT;
        end
        S_OUT: begin
          if (rx_ready) begin
            if (count != len_q) begin
              count <= count + 1'b1;
              state <= S_SEND;
            end else begin
              state <= keep_q ? S_FIN : S_CSOFF;
            end
          end
        end
        S_CSOFF: begin
          if (last) begin
            cs_on <= 1'b0;
            state <= S_FIN;
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_xfer_ctrl.sv
// Bench for sd_spi_xfer_ctrl: behavioural SPI core register model plus RX/bus-write scoreboards.
module tb_sd_spi_xfer_ctrl;
  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_fill = 1'b0;
  logic             cmd_keep_cs = 1'b0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       tx_data = '0;
  logic             rx_valid;
  logic             rx_ready = 1'b1;
  logic [7:0]       rx_data;
  logic             done;
  logic             err_overrun;
  logic             err_timeout;
  logic             spi_select;
  logic [2:0]       spi_mem_addr;
  logic             spi_read_n;
  logic             spi_write_n;
  logic [15:0]      spi_wdata;
  logic [15:0]      spi_rdata;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  // SPI core model state
  logic       m_rrdy = 1'b0, m_roe = 1'b0, m_sso = 1'b0;
  logic [7:0] m_rx = '0, m_pend = '0;
  int         m_busy = 0;
  logic       m_stall = 1'b0, roe_inject = 1'b0;
  logic       wr_prev = 1'b0, rd_prev = 1'b0;
  int         wr1_cnt = 0, poll_cnt = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  miso_q[$];
  logic [7:0]  exp_rx[$];
  logic [18:0] exp_wr[$];
  logic [18:0] act_wr[$];
  bit          cs_exp = 1'b0;

  always #5 clk = ~clk;

  sd_spi_xfer_ctrl #(
    .LEN_W(LEN_W),
    .FILL_BYTE(8'hFF),
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_fill(cmd_fill), .cmd_keep_cs(cmd_keep_cs),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .done(done), .err_overrun(err_overrun), .err_timeout(err_timeout),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr), .spi_read_n(spi_read_n),
    .spi_write_n(spi_write_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata)
  );

  // status: RRDY=7 TRDY=6 TMT=5 TOE=4 ROE=3
  assign spi_rdata = (!spi_read_n && spi_mem_addr == 3'd0) ? {8'h00, m_rx} :
                     (!spi_read_n && spi_mem_addr == 3'd2) ? {8'h00, m_rrdy, 2'b11, 1'b0, m_roe, 3'b000} :
                     16'h0000;

  always @(negedge clk) begin
    if (reset) begin
      m_rrdy  <= 1'b0;
      m_roe   <= 1'b0;
      m_sso   <= 1'b0;
      m_busy  <= 0;
      wr_prev <= 1'b0;
      rd_prev <= 1'b0;
    end else begin
      wr_prev <= spi_select && !spi_write_n;
      rd_prev <= spi_select && !spi_read_n;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1 && !m_stall) begin
          m_rrdy <= 1'b1;
          m_rx   <= m_pend;
          if (roe_inject) m_roe <= 1'b1;
        end
      end
      if (spi_select && !spi_write_n && !wr_prev) begin
        act_wr.push_back({spi_mem_addr, spi_wdata});
        if (spi_mem_addr == 3'd1) begin
          wr1_cnt <= wr1_cnt + 1;
          m_busy  <= 5;
          if (miso_q.size() > 0) m_pend <= miso_q.pop_front();
          else m_pend <= 8'h00;
        end else if (spi_mem_addr == 3'd2) begin
          m_rrdy <= 1'b0;
          m_roe  <= 1'b0;
        end else if (spi_mem_addr == 3'd3) begin
          m_sso <= spi_wdata[10];
        end
      end
      if (spi_select && !spi_read_n && !rd_prev) begin
        if (spi_mem_addr == 3'd0) m_rrdy <= 1'b0;
        else if (spi_mem_addr == 3'd2) poll_cnt <= poll_cnt + 1;
      end
    end
  end

  task automatic queue_cmd(input int len, input bit fill, input bit keep);
    logic [7:0] b, r;
    exp_wr.push_back({3'd2, 16'h0000});
    if (!cs_exp) begin
      exp_wr.push_back({3'd3, 16'h0400});
      cs_exp = 1'b1;
    end
    for (int i = 0; i <= len; i++) begin
      b = 8'($urandom_range(0, 255));
      r = 8'($urandom_range(0, 255));
      if (!fill) tx_q.push_back(b);
      miso_q.push_back(r);
      exp_rx.push_back(r);
      exp_wr.push_back({3'd1, fill ? 16'h00FF : {8'h00, b}});
    end
    if (!keep) begin
      exp_wr.push_back({3'd3, 16'h0000});
      cs_exp = 1'b0;
    end
  endtask

  task automatic clear_queues();
    tx_q.delete(); miso_q.delete(); exp_rx.delete(); exp_wr.delete(); act_wr.delete();
  endtask

  task automatic do_cmd(input int len, input bit fill, input bit keep,
                        input int stall_idx, input int stall_cyc, input int abort_idx,
                        input int budget, input bit expect_done,
                        output bit got_done, output bit aborted, output bit e_ovr, output bit e_tmo);
    int idx = 0, stall_left = 0, wr1_at = 0;
    bit seen = 0, tx_hs = 0, rx_hs = 0;
    logic [7:0] held = '0, er;
    logic [18:0] ew, aw;
    got_done = 0; aborted = 0; e_ovr = 0; e_tmo = 0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_len = LEN_W'(len); cmd_fill = fill; cmd_keep_cs = keep;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++;
    if ({spi_select, spi_write_n, spi_mem_addr} !== {1'b1, 1'b0, 3'd2}) begin
      bad++; $display("FAIL first_access: got sel=%b wr_n=%b addr=%0d want sel=1 wr_n=0 addr=2",
                      spi_select, spi_write_n, spi_mem_addr);
    end
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (tx_hs) void'(tx_q.pop_front());
      if (rx_hs) begin idx++; seen = 0; end
      if (done) begin
        got_done = 1; e_ovr = err_overrun; e_tmo = err_timeout;
        break;
      end
      if (abort_idx >= 0 && idx == abort_idx && !spi_read_n && spi_mem_addr == 3'd2) begin
        aborted = 1;
        break;
      end
      if (rx_valid && !seen) begin
        seen = 1;
        total++;
        if (exp_rx.size() == 0) begin
          bad++; $display("FAIL rx_extra: got %h want no byte", rx_data);
        end else begin
          er = exp_rx.pop_front();
          if (rx_data !== er) begin
            bad++; $display("FAIL rx_data[%0d]: got %h want %h", idx, rx_data, er);
          end
        end
        if (idx == stall_idx) begin
          stall_left = stall_cyc; held = rx_data; wr1_at = wr1_cnt;
        end
      end
      if (rx_valid && stall_left > 0) begin
        rx_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) begin
          total++;
          if ({rx_valid, rx_data} !== {1'b1, held} || wr1_cnt != wr1_at) begin
            bad++; $display("FAIL backpressure_hold: got v=%b d=%h wr1=%0d want v=1 d=%h wr1=%0d",
                            rx_valid, rx_data, wr1_cnt, held, wr1_at);
          end
        end
      end else begin
        rx_ready = 1'b1;
      end
      tx_valid = (tx_q.size() > 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      #1;
      tx_hs = tx_ready && tx_valid;
      rx_hs = rx_valid && rx_ready;
      if (tx_ready && rx_valid) overlap++;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    if (expect_done) begin
      total++;
      if (!got_done) begin
        bad++; $display("FAIL done_wait: got no done within %0d cycles want done", budget);
      end
      total++;
      if (act_wr.size() != exp_wr.size() || exp_rx.size() != 0) begin
        bad++; $display("FAIL bus_count: got writes=%0d rx_left=%0d want writes=%0d rx_left=0",
                        act_wr.size(), exp_rx.size(), exp_wr.size());
      end
      while (act_wr.size() > 0 && exp_wr.size() > 0) begin
        aw = act_wr.pop_front();
        ew = exp_wr.pop_front();
        total++;
        if (aw !== ew) begin
          bad++; $display("FAIL bus_write: got addr=%0d data=%h want addr=%0d data=%h",
                          aw[18:16], aw[15:0], ew[18:16], ew[15:0]);
        end
      end
      clear_queues();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, tx_ready, rx_valid, done, err_overrun, err_timeout} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 100000",
                      {cmd_ready, tx_ready, rx_valid, done, err_overrun, err_timeout});
    end
    total++;
    if ({spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wdata} !== {1'b0, 1'b1, 1'b1, 3'd0, 16'h0000}) begin
      bad++; $display("FAIL reset_bus: got sel=%b rd_n=%b wr_n=%b addr=%0d wdata=%h want 0 1 1 0 0000",
                      spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_wdata);
    end
    reset = 1'b0;
    cs_exp = 1'b0;
  endtask

  task automatic test_single();
    bit d, a, eo, et;
    tx_q.push_back(8'h40);
    miso_q.push_back(8'hA5);
    exp_rx.push_back(8'hA5);
    exp_wr.push_back({3'd2, 16'h0000});
    exp_wr.push_back({3'd3, 16'h0400});
    exp_wr.push_back({3'd1, 16'h0040});
    exp_wr.push_back({3'd3, 16'h0000});
    do_cmd(0, 1'b0, 1'b0, -1, 0, -1, 500, 1'b1, d, a, eo, et);
    total++;
    if ({eo, et, m_sso} !== 3'b000) begin
      bad++; $display("FAIL single_end: got ovr=%b tmo=%b sso=%b want 0 0 0", eo, et, m_sso);
    end
  endtask

  task automatic test_fill();
    bit d, a, eo, et;
    queue_cmd(511, 1'b1, 1'b0);
    do_cmd(511, 1'b1, 1'b0, -1, 0, -1, 20000, 1'b1, d, a, eo, et);
    total++;
    if ({eo, et, m_sso} !== 3'b000) begin
      bad++; $display("FAIL fill_end: got ovr=%b tmo=%b sso=%b want 0 0 0", eo, et, m_sso);
    end
  endtask

  task automatic test_backpressure();
    bit d, a, eo, et;
    queue_cmd(5, 1'b0, 1'b0);
    do_cmd(5, 1'b0, 1'b0, 2, 100, -1, 2000, 1'b1, d, a, eo, et);
  endtask

  task automatic test_chain();
    bit d, a, eo, et;
    queue_cmd(1, 1'b0, 1'b1);
    do_cmd(1, 1'b0, 1'b1, -1, 0, -1, 1000, 1'b1, d, a, eo, et);
    total++;
    if (m_sso !== 1'b1) begin
      bad++; $display("FAIL chain_ss_held: got sso=%b want 1", m_sso);
    end
    queue_cmd(0, 1'b1, 1'b0);
    do_cmd(0, 1'b1, 1'b0, -1, 0, -1, 1000, 1'b1, d, a, eo, et);
    total++;
    if (m_sso !== 1'b0) begin
      bad++; $display("FAIL chain_ss_end: got sso=%b want 0", m_sso);
    end
  endtask

  task automatic test_overrun();
    bit d, a, eo, et;
    roe_inject = 1'b1;
    queue_cmd(0, 1'b1, 1'b0);
    do_cmd(0, 1'b1, 1'b0, -1, 0, -1, 500, 1'b1, d, a, eo, et);
    total++;
    if (eo !== 1'b1) begin
      bad++; $display("FAIL overrun_set: got %b want 1", eo);
    end
    roe_inject = 1'b0;
    queue_cmd(0, 1'b1, 1'b0);
    do_cmd(0, 1'b1, 1'b0, -1, 0, -1, 500, 1'b1, d, a, eo, et);
    total++;
    if (eo !== 1'b0) begin
      bad++; $display("FAIL overrun_clear: got %b want 0", eo);
    end
  endtask

  task automatic test_stall_timeout();
    bit d, a, eo, et;
    int p0;
    m_stall = 1'b1;
`ifdef SD_SPI_CTRL_TIMEOUT_EN
    exp_wr.push_back({3'd2, 16'h0000});
    exp_wr.push_back({3'd3, 16'h0400});
    exp_wr.push_back({3'd1, 16'h00FF});
    exp_wr.push_back({3'd3, 16'h0000});
    miso_q.push_back(8'h5A);
    do_cmd(3, 1'b1, 1'b1, -1, 0, -1, 3000, 1'b1, d, a, eo, et);
    total++;
    if ({et, m_sso} !== 2'b10) begin
      bad++; $display("FAIL timeout_flag: got tmo=%b sso=%b want 1 0", et, m_sso);
    end
    cs_exp = 1'b0;
`else
    p0 = poll_cnt;
    do_cmd(3, 1'b1, 1'b1, -1, 0, -1, 1000, 1'b0, d, a, eo, et);
    total++;
    if (d || cmd_ready !== 1'b0 || (poll_cnt - p0) < 100) begin
      bad++; $display("FAIL stall_poll: got done=%b cmd_ready=%b polls=%0d want 0 0 >=100",
                      d, cmd_ready, poll_cnt - p0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_queues();
    cs_exp = 1'b0;
`endif
    m_stall = 1'b0;
  endtask

  task automatic test_reset_midburst();
    bit d, a, eo, et;
    queue_cmd(9, 1'b1, 1'b0);
    do_cmd(9, 1'b1, 1'b0, -1, 0, 4, 3000, 1'b0, d, a, eo, et);
    total++;
    if (a !== 1'b1) begin
      bad++; $display("FAIL abort_point: got %b want 1", a);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, tx_ready, rx_valid, done, spi_select, spi_read_n, spi_write_n, spi_mem_addr} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0}) begin
      bad++; $display("FAIL midburst_reset: got rdy=%b txr=%b rxv=%b done=%b sel=%b rd_n=%b wr_n=%b addr=%0d want 1 0 0 0 0 1 1 0",
                      cmd_ready, tx_ready, rx_valid, done, spi_select, spi_read_n, spi_write_n, spi_mem_addr);
    end
    reset = 1'b0;
    clear_queues();
    cs_exp = 1'b0;
    queue_cmd(1, 1'b1, 1'b0);
    do_cmd(1, 1'b1, 1'b0, -1, 0, -1, 1000, 1'b1, d, a, eo, et);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_chain();
    test_overrun();
    test_stall_timeout();
    test_reset_midburst();
    total++;
    if (overlap != 0) begin
      bad++; $display("FAIL tx_rx_exclusive: got %0d overlapping cycles want 0", overlap);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
